// File: rtl/pcs_sync_pkg.sv
// Shared encodings and sizing helpers for the PCS receive-sync controller.
// Also used by the testbench.
package pcs_sync_pkg;

    localparam int CG_W    = 10;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_POWERUP  = 3'd0,
        ST_WAIT_SIG = 3'd1,
        ST_ACQUIRE  = 3'd2,
        ST_LINK_UP  = 3'd3,
        ST_HOLDOFF  = 3'd4
    } ctrl_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sig_detect_debounce.sv
// Two-flop synchronizer for the asynchronous PMA signal detect, followed by a run-length
// debouncer that flips its level only after DEB_CYCLES consecutive differing samples.
module sig_detect_debounce
    import pcs_sync_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic level_o,
    output logic change_o
);

    localparam int RUN_W = cnt_width(DEB_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             change_q;
    logic [RUN_W-1:0] run_q;
    logic             differs;

    assign differs  = (sync2_q != level_q);
    assign level_o  = level_q;
    assign change_o = change_q;

    // NOTE: every register here uses <= so all flops sample the same pre-edge values;
    // a blocking '=' would let sync2_q see the new sync1_q and remove a synchronizer stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            change_q <= 1'b0;
            run_q    <= '0;
        end else begin
            sync1_q  <= sig_i;
            sync2_q  <= sync1_q;
            change_q <= 1'b0;
            if (!differs) begin
                run_q <= '0;
            end else if (run_q == RUN_W'(DEB_CYCLES - 1)) begin
                level_q  <= sync2_q;
                change_q <= 1'b1;
                run_q    <= '0;
            end else begin
                run_q <= run_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcs_sync_ctrl.sv
// Sequencer for the PCS receive synchronization FSM. It drives POWER, RESET and
// SIGNAL_CHANGE, muxes PUDI for loopback, and retries sync acquisition on a watchdog.
module pcs_sync_ctrl
    import pcs_sync_pkg::*;
#(
    parameter int PWR_CYCLES  = 16,
    parameter int DEB_CYCLES  = 4,
    parameter int ACQ_TIMEOUT = 1024,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CG_W-1:0]    pma_rx_i,
    input  logic [CG_W-1:0]    tx_loop_i,
    input  logic               mr_loopback_i,
    input  logic               signal_detect_in_i,
    input  logic               code_sync_i,
    output logic               sync_power_o,
    output logic               sync_reset_o,
    output logic               sync_signal_change_o,
    output logic               sync_signal_detect_o,
    output logic [CG_W-1:0]    sync_pudi_o,
    output logic               sync_loopback_o,
    output logic               link_ok_o,
    output logic [CNT_W-1:0]   resync_cnt_o,
    output logic [STATE_W-1:0] ctrl_state_o
);

    localparam int PWR_W  = cnt_width(PWR_CYCLES);
    localparam int TMR_W  = cnt_width(ACQ_TIMEOUT);
    localparam int HOLD_W = cnt_width(HOLD_CYCLES);

    ctrl_state_e       state_q;
    logic              sync_power_q;
    logic              sync_reset_q;
    logic              link_ok_q;
    logic              loopback_q;
    logic [CG_W-1:0]   pudi_q;
    logic [CNT_W-1:0]  resync_cnt_q;
    logic [CNT_W-1:0]  resync_cnt_d;
    logic [PWR_W-1:0]  pwr_q;
    logic [TMR_W-1:0]  timer_q;
    logic [HOLD_W-1:0] hold_q;

    logic deb_level;
    logic deb_change;
    logic det;
    logic lb_toggle;

    sig_detect_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .sig_i    (signal_detect_in_i),
        .level_o  (deb_level),
        .change_o (deb_change)
    );

    assign det          = deb_level | loopback_q;
    assign lb_toggle    = (mr_loopback_i != loopback_q);
    assign resync_cnt_d = (&resync_cnt_q) ? resync_cnt_q : resync_cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_POWERUP;
            sync_power_q <= 1'b1;
            sync_reset_q <= 1'b0;
            link_ok_q    <= 1'b0;
            loopback_q   <= 1'b0;
            pudi_q       <= '0;
            resync_cnt_q <= '0;
            pwr_q        <= '0;
            timer_q      <= '0;
            hold_q       <= '0;
        end else begin
            loopback_q <= mr_loopback_i;
            pudi_q     <= mr_loopback_i ? tx_loop_i : pma_rx_i;

            if (state_q == ST_POWERUP) begin
                if (pwr_q == PWR_W'(PWR_CYCLES - 1)) begin
                    sync_power_q <= 1'b0;
                    state_q      <= ST_WAIT_SIG;
                end else begin
                    pwr_q <= pwr_q + 1'b1;
                end
            end else if (lb_toggle) begin
                // A loopback switch changes the code-group source, so restart sync from scratch.
                sync_reset_q <= 1'b1;
                link_ok_q    <= 1'b0;
                state_q      <= ST_WAIT_SIG;
            end else begin
                sync_reset_q <= 1'b0;
                case (state_q)
                    ST_WAIT_SIG: begin
                        if (det) begin
                            state_q <= ST_ACQUIRE;
                            timer_q <= '0;
                        end
                    end
                    ST_ACQUIRE: begin
                        if (!det) begin
                            state_q <= ST_WAIT_SIG;
                        end else if (code_sync_i) begin
                            state_q   <= ST_LINK_UP;
                            link_ok_q <= 1'b1;
                        end else if (timer_q == TMR_W'(ACQ_TIMEOUT - 1)) begin
                            state_q      <= ST_HOLDOFF;
                            sync_reset_q <= 1'b1;
                            resync_cnt_q <= resync_cnt_d;
                            hold_q       <= '0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    ST_LINK_UP: begin
                        if (!det) begin
                            state_q   <= ST_WAIT_SIG;
                            link_ok_q <= 1'b0;
                        end else if (!code_sync_i) begin
                            state_q   <= ST_ACQUIRE;
                            timer_q   <= '0;
                            link_ok_q <= 1'b0;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                            state_q <= ST_WAIT_SIG;
                        end else begin
                            sync_reset_q <= 1'b1;
                            hold_q       <= hold_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_WAIT_SIG;
                endcase
            end
        end
    end

    assign sync_power_o         = sync_power_q;
    assign sync_reset_o         = sync_reset_q;
    assign sync_signal_change_o = deb_change;
    assign sync_signal_detect_o = deb_level;
    assign sync_pudi_o          = pudi_q;
    assign sync_loopback_o      = loopback_q;
    assign link_ok_o            = link_ok_q;
    assign resync_cnt_o         = resync_cnt_q;
    assign ctrl_state_o         = state_q;

endmodule
